// File: rtl/beep_pkg.sv
// beep_pkg: shared definitions for the beep_jingle buzzer block.
//   - game mode encodings that trigger a jingle
//   - FSM state and melody select enums
//   - half-period tables (cycles at 100 MHz) for the two four-note melodies
package beep_pkg;

    localparam logic [1:0] MODE_WAIT = 2'b00;
    localparam logic [1:0] MODE_OVER = 2'b11;

    localparam int TONE_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MEL_START = 1'b0,
        MEL_OVER  = 1'b1
    } melody_t;

    // Element [0] is the first note of each melody.
    // START: C5 E5 G5 C6 (rising), OVER: G4 F4 E4 C4 (falling).
    localparam logic [3:0][TONE_W-1:0] HALF_START = {
        18'd47755, 18'd63775, 18'd75872, 18'd95602
    };
    localparam logic [3:0][TONE_W-1:0] HALF_OVER = {
        18'd190839, 18'd151515, 18'd143266, 18'd127551
    };

    // True for the two modes that start a jingle.
    function automatic logic is_jingle_mode(input logic [1:0] mode);
        return (mode == MODE_WAIT) || (mode == MODE_OVER);
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// beep_tone_gen: square-wave divider for the buzzer.
//   clk          in  : system clock
//   rst          in  : synchronous active-high reset
//   half_period  in  : cycles per half wave (counter wraps at half_period-1)
//   enable       in  : count while high, hold otherwise
//   restart      in  : clear counter and force tone low (wins over enable)
//   tone         out : registered square wave, starts low after restart
module beep_tone_gen
    import beep_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TONE_W-1:0] half_period,
    input  logic              enable,
    input  logic              restart,
    output logic              tone
);

    logic [TONE_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_reg <= '0;
            tone    <= 1'b0;
        end else if (enable) begin
            // >= keeps the divider sane if the period shrinks mid-count
            if (cnt_reg >= half_period - TONE_W'(1)) begin
                cnt_reg <= '0;
                tone    <= ~tone;
            end else begin
                cnt_reg <= cnt_reg + TONE_W'(1);
            end
        end
    end

endmodule

// File: rtl/beep_jingle.sv
// beep_jingle: plays a rising four-note jingle when the game enters the
// waiting mode (00) and a falling one when it enters game over (11).
//   clk       in  : system clock
//   rst       in  : synchronous active-high reset
//   gamemode  in  : 00 wait, 01/10 playing, 11 game over
//   beep      out : registered buzzer square wave
//   playing   out : registered, high while a jingle is in progress
// Parameters:
//   CLK_HZ     : clock frequency, informational (tables assume 100 MHz)
//   NOTE_TICKS : cycles per note slot
//   TONE_DIV   : divides every half period; 1 gives the real pitches,
//                larger values give fast-running simulations
module beep_jingle
    import beep_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NOTE_TICKS = 15_000_000,
    parameter int TONE_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gamemode,
    output logic       beep,
    output logic       playing
);

    localparam int  SLOT_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NOTE_TICKS - 1);
    // A non-positive clock setting mutes the block instead of misbehaving.
    localparam bit  CLK_OK = (CLK_HZ > 0);

    state_t            state_reg;
    melody_t           melody_reg;
    logic [1:0]        prev_mode_reg;
    logic [1:0]        note_reg;
    logic [SLOT_W-1:0] slot_reg;

    logic [3:0][TONE_W-1:0] start_tbl;
    logic [3:0][TONE_W-1:0] over_tbl;
    logic [TONE_W-1:0]      half_sel;

    logic entry_evt;
    logic abort_evt;
    logic slot_wrap;

    // Scaled period tables; constant expressions, folded at elaboration.
    for (genvar gi = 0; gi < 4; gi++) begin : g_tbl
        assign start_tbl[gi] = TONE_W'(int'(HALF_START[gi]) / TONE_DIV);
        assign over_tbl[gi]  = TONE_W'(int'(HALF_OVER[gi])  / TONE_DIV);
    end

    assign half_sel = (melody_reg == MEL_OVER) ? over_tbl[note_reg]
                                               : start_tbl[note_reg];

    assign entry_evt = is_jingle_mode(gamemode) && (gamemode != prev_mode_reg);
    assign abort_evt = !is_jingle_mode(gamemode) && (gamemode != prev_mode_reg);
    assign slot_wrap = (state_reg == ST_PLAY) && (slot_reg == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            melody_reg    <= MEL_START;
            // 01 here lets a 00 held through reset count as a fresh entry
            prev_mode_reg <= 2'b01;
            note_reg      <= 2'd0;
            slot_reg      <= '0;
            playing       <= 1'b0;
        end else begin
            prev_mode_reg <= gamemode;
            if (entry_evt) begin
                state_reg  <= ST_PLAY;
                melody_reg <= (gamemode == MODE_OVER) ? MEL_OVER : MEL_START;
                note_reg   <= 2'd0;
                slot_reg   <= '0;
                playing    <= 1'b1;
            end else if (abort_evt) begin
                state_reg <= ST_IDLE;
                note_reg  <= 2'd0;
                slot_reg  <= '0;
                playing   <= 1'b0;
            end else if (state_reg == ST_PLAY) begin
                if (slot_wrap) begin
                    slot_reg <= '0;
                    if (note_reg == 2'd3) begin
                        state_reg <= ST_DONE;
                        note_reg  <= 2'd0;
                        playing   <= 1'b0;
                    end else begin
                        note_reg <= note_reg + 2'd1;
                    end
                end else begin
                    slot_reg <= slot_reg + SLOT_W'(1);
                end
            end
        end
    end

    // Restart on every event that must leave the buzzer low on the next
    // edge: new jingle, abort, and each note boundary (including the end).
    beep_tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .half_period (half_sel),
        .enable      ((state_reg == ST_PLAY) && CLK_OK),
        .restart     (entry_evt || abort_evt || slot_wrap),
        .tone        (beep)
    );

endmodule

// File: tb/tb_beep_jingle.sv
// tb_beep_jingle: directed scenarios plus random mode/reset traffic, every
// cycle compared against a jingle model that derives the expected buzzer
// level from the elapsed time since the last entry event.
module tb_beep_jingle;

    localparam int NT  = 2000;   // NOTE_TICKS
    localparam int DIV = 128;    // TONE_DIV

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gamemode = 2'b00;
    logic       beep;
    logic       playing;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    bit         m_active = 1'b0;
    bit         m_over   = 1'b0;
    int         m_j      = 0;
    logic [1:0] m_prev   = 2'b01;

    always #5 clk = ~clk;

    beep_jingle #(
        .CLK_HZ     (100_000_000),
        .NOTE_TICKS (NT),
        .TONE_DIV   (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gamemode (gamemode),
        .beep     (beep),
        .playing  (playing)
    );

    function automatic int half(input bit ov, input int n);
        int h;
        case (n)
            0:       h = ov ? 127551 :  95602;
            1:       h = ov ? 143266 :  75872;
            2:       h = ov ? 151515 :  63775;
            default: h = ov ? 190839 :  47755;
        endcase
        return h / DIV;
    endfunction

    // Apply one clock edge's worth of rules to the model.
    task automatic model_edge(input logic r, input logic [1:0] gm);
        bit jingle_mode;
        jingle_mode = (gm == 2'b00) || (gm == 2'b11);
        if (r) begin
            m_active = 1'b0;
            m_prev   = 2'b01;
        end else begin
            if (jingle_mode && gm != m_prev) begin
                m_active = 1'b1;
                m_over   = (gm == 2'b11);
                m_j      = 0;
            end else if (!jingle_mode && gm != m_prev) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_j++;
                if (m_j >= 4 * NT) m_active = 1'b0;
            end
            m_prev = gm;
        end
    endtask

    task automatic tick();
        logic exp_beep;
        logic exp_play;
        @(posedge clk);
        cyc++;
        model_edge(rst, gamemode);
        #1;
        exp_play = m_active;
        if (m_active)
            exp_beep = (((m_j % NT) / half(m_over, m_j / NT)) % 2) == 1;
        else
            exp_beep = 1'b0;
        checks++;
        assert (playing === exp_play) else begin
            failures++;
            $error("FAIL playing cyc=%0d got=%b exp=%b", cyc, playing, exp_play);
        end
        checks++;
        assert (beep === exp_beep) else begin
            failures++;
            $error("FAIL beep cyc=%0d got=%b exp=%b (j=%0d over=%0b)",
                   cyc, beep, exp_beep, m_j, m_over);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // reset with 00 held: silent during reset, start jingle on release
        rst = 1'b1; gamemode = 2'b00;
        run(3);
        rst = 1'b0;
        run(4 * NT + 200);

        // 01 -> 11: game-over jingle, then hold 11 silently
        gamemode = 2'b01; run(10);
        gamemode = 2'b11; run(4 * NT + 300);

        // start jingle aborted inside note 0
        gamemode = 2'b01; run(10);
        gamemode = 2'b00; run(1200);
        gamemode = 2'b01; run(20);

        // start jingle overridden by game over in note 1
        gamemode = 2'b00; run(NT + 800);
        gamemode = 2'b11; run(1500);

        // reset pulse mid-jingle with 00 held
        gamemode = 2'b00; run(NT + 1200);
        rst = 1'b1; run(3);
        rst = 1'b0; run(1500);

        // 00 -> 01 -> 00 replays the start jingle
        gamemode = 2'b01; run(5);
        gamemode = 2'b00; run(2500);

        // random mode changes and occasional reset
        for (int s = 0; s < 30; s++) begin
            gamemode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 15) == 0);
            run(rst ? 2 : int'($urandom_range(5, 900)));
            rst = 1'b0;
        end
        run(4 * NT + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
